// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between the instruction fetch path and
// the data path. Data has priority; a starvation counter forces an
// instruction grant after STARVE_LIMIT back-to-back data completions while
// an instruction fetch is pending. A registered FSM serializes transactions;
// iwait/dwait form the handshake toward each requester.
// Optional feature: define MEM_ARB_WATCHDOG_EN to build a per-grant watchdog
// that aborts a grant after TIMEOUT cycles without ACCESS or ERROR.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  // instruction requester
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  // data requester
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  // RAM port
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  // status
  output logic        err
);

  // FSM encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DGRANT = 2'd1;
  localparam logic [1:0] IGRANT = 2'd2;

  // RAM status encoding
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SLIM = SC_W'(STARVE_LIMIT);

  // Reject degenerate configurations at elaboration time.
  if (STARVE_LIMIT < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("memory_arbiter: STARVE_LIMIT and TIMEOUT must be at least 1");
  end

  logic [1:0]      state_q, state_d;
  logic [SC_W-1:0] starve_q, starve_d;
  logic            err_q, err_d;

  logic d_req;
  logic ram_acc;
  logic ram_err;
  logic in_dgrant;
  logic in_igrant;
  logic in_grant;
  logic d_done;
  logic i_done;
  logic wd_hit;

  assign d_req     = dREN | dWEN;
  assign ram_acc   = (ramstate == RAM_ACCESS);
  assign ram_err   = (ramstate == RAM_ERROR);
  assign in_dgrant = (state_q == DGRANT);
  assign in_igrant = (state_q == IGRANT);
  assign in_grant  = in_dgrant | in_igrant;
  // A completion needs the granted request to still be present; a dropped
  // request in the ACCESS cycle counts as an abort, not a completion.
  assign d_done    = in_dgrant & d_req & ram_acc;
  assign i_done    = in_igrant & iREN & ram_acc;

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] TO_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_inc;

  // Count stalled grant cycles; the TIMEOUT-th stalled cycle fires the hit.
  assign wd_inc = in_grant & ~ram_acc & ~ram_err;
  assign wd_hit = wd_inc & (wd_q == TO_LAST);

  // Watchdog next count; zero whenever idle so every grant starts fresh
  always_comb begin
    wd_d = '0;
    if (wd_inc) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  // Without the watchdog a grant waits for ACCESS or ERROR indefinitely.
  assign wd_hit = 1'b0;
`endif

  // Arbitration and grant-termination decisions
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req && (!iREN || (starve_q < SLIM))) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!d_req || ram_acc || ram_err || wd_hit) begin
          state_d = IDLE;
        end
      end
      IGRANT: begin
        if (!iREN || ram_acc || ram_err || wd_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter: data completions while a fetch waits, cleared when
  // the fetch is served or withdrawn
  always_comb begin
    starve_d = starve_q;
    if (!iREN) begin
      starve_d = '0;
    end else if (i_done) begin
      starve_d = '0;
    end else if (d_done && (starve_q < SLIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Sticky error flag: RAM error or watchdog expiry during any grant
  always_comb begin
    err_d = err_q | (in_grant & (ram_err | wd_hit));
  end

  // Control registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // RAM port mux, handshake waits and read-data passthrough
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN & ~(in_igrant & ram_acc);
    dwait    = d_req & ~(in_dgrant & ram_acc);
    iload    = i_done ? ramload : '0;
    dload    = d_done ? ramload : '0;
    case (state_q)
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  assign err = err_q;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter that shares the single RAM port between the instruction path and the data path of the pipelined processor. It sits between the datapath's cache interface (imem/dmem request signals) and the RAM model. Data accesses get priority, with a starvation counter that guarantees instruction fetch progress. A registered FSM serializes transactions, and the per-requester wait signals provide the handshake.

## Interface
Parameters:
- STARVE_LIMIT, 4, number of consecutive data grants completed while iREN is held before instruction gets priority.
- TIMEOUT, 64, watchdog cycle limit per grant; used only with MEM_ARB_WATCHDOG_EN.

Ports (one clock; reset asynchronous, active-low):
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction address.
- iload  out  32  instruction read data; valid when iREN & !iwait.
- iwait  out  1  instruction stall.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data; valid when dREN & !dwait.
- dwait  out  1  data stall.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- err  out  1  sticky error flag.

## Operation
- FSM states:
  - IDLE: drives no RAM request.
  - DGRANT: RAM port mux selects the data requester.
  - IGRANT: RAM port mux selects the instruction requester.
- IDLE, next state:
  - DGRANT if (dREN|dWEN) and (!iREN or starve_cnt < STARVE_LIMIT).
  - Else IGRANT if iREN.
  - Else stay in IDLE.
- DGRANT outputs:
  - ramWEN = dWEN.
  - ramREN = dREN & !dWEN; write wins when both are set.
  - ramaddr = daddr; ramstore = dstore.
- IGRANT outputs: ramREN = iREN, ramWEN = 0, ramaddr = iaddr, ramstore = 0.
- In IDLE, ramREN = ramWEN = 0 and ramaddr = ramstore = 0.
- Completion happens when ramstate == ACCESS in a grant state:
  - The granted wait is deasserted that same cycle.
  - iload/dload = ramload, combinational passthrough.
  - Next state is IDLE.
- iwait = iREN & !(IGRANT & ACCESS).
- dwait = (dREN|dWEN) & !(DGRANT & ACCESS).
- iload/dload are 0 when not completing.
- Abort: in a grant state, if the granted request drops, the FSM returns to IDLE next cycle with no completion and no counter change.
- ERROR while in a grant state: err set (sticky), FSM returns to IDLE, wait stays high, and the request is retried by normal arbitration.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments on each DGRANT completion while iREN = 1, saturating at STARVE_LIMIT.
  - Clears on IGRANT completion or any cycle with iREN = 0.
- err clears only on reset.

## Timing
- Reset values: state IDLE, starve_cnt 0, err 0, watchdog count 0.
  - This gives ramREN = ramWEN = 0 and ramaddr = ramstore = 0.
  - Waits equal the raw requests.
- Latency: a request seen in IDLE at cycle N gives the grant state at N+1, with the RAM request driven at N+1.
- Completion occurs in the first cycle at or after N+1 with ramstate == ACCESS.
- Minimum request-to-completion latency: 1 cycle plus the RAM latency.
- At least one IDLE cycle separates back-to-back transactions, so the arbitration decision is always made in IDLE.
- Simultaneous iREN and dREN in IDLE with starve_cnt < STARVE_LIMIT: DGRANT.
- Simultaneous iREN and dREN in IDLE with starve_cnt == STARVE_LIMIT: IGRANT.
- Reset asserted mid-transaction: immediate return to IDLE and RAM enables drop asynchronously; no completion is reported.

## Configuration
- MEM_ARB_WATCHDOG_EN defined:
  - A counter of width $clog2(TIMEOUT+1) counts cycles in a grant state without ACCESS or ERROR; it clears on entering a grant.
  - When it reaches TIMEOUT: err set and FSM returns to IDLE, as for ERROR.
- MEM_ARB_WATCHDOG_EN undefined:
  - No counter is built and TIMEOUT is unused.
  - A grant waits indefinitely for ACCESS.
  - err is set only by ramstate ERROR.

## Test plan
- Reset, then iREN = 1, iaddr = 0x40, RAM gives ACCESS 2 cycles after the request with ramload = 0x2402000A:
  - IGRANT at cycle 1, ramREN = 1, ramaddr = 0x40.
  - iwait low with iload = 0x2402000A in the ACCESS cycle, then IDLE.
- dWEN = 1, daddr = 0x80, dstore = 0xDEADBEEF, with iREN = 1 simultaneously:
  - DGRANT first, ramWEN = 1, ramstore = 0xDEADBEEF.
  - iwait stays high until the data completes, then IGRANT.
- Continuous dREN and iREN, STARVE_LIMIT = 4: exactly 4 data completions, then one instruction completion, then data resumes.
- dREN = dWEN = 1: ramWEN = 1 and ramREN = 0.
- dREN dropped while in DGRANT before ACCESS: IDLE next cycle, no dload, starve_cnt unchanged.
- ramstate = ERROR during IGRANT: err = 1 and stays set, FSM goes to IDLE then regrants.
  - With MEM_ARB_WATCHDOG_EN and TIMEOUT = 64 and ramstate held BUSY: err = 1 after 64 grant cycles.
